mips_cycle_ctrl: RTL and testbench
==================================

MIPS_CYCLE_CTRL -- requirements
Module: mips_cycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the cycle counter, burst length and run count.
REQ-002 SHALL have parameter N_CH, default 1: number of independently maskable core-enable channels.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 2 bits: 0 HALT, 1 FREE, 2 BURST, 3 STEP; sampled only on an accepted start.
REQ-006 SHALL have port start, input, 1 bit: request a run; accepted only in IDLE.
REQ-007 SHALL have port stop, input, 1 bit: abort a run.
REQ-008 SHALL have port burst_len, input, CNT_W bits: cycle count for BURST; sampled on an accepted start.
REQ-009 SHALL have port ch_mask, input, N_CH bits: channel enable mask; sampled on an accepted start.
REQ-010 SHALL have port step_en, output, N_CH bits: per-channel core clock-enable.
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a run ends.
REQ-013 SHALL have port cycles_run, output, CNT_W bits: number of enabled cycles in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and FINISH.
REQ-015 SHALL go IDLE->RUN on start when mode != HALT; start with mode HALT SHALL be ignored.
REQ-016 SHALL clear cycles_run to 0 on an accepted start.
REQ-017 SHALL drive step_en = latched mask in every RUN cycle, and 0 in IDLE and FINISH.
REQ-018 SHALL increment cycles_run by 1 in every RUN cycle, saturating at 2^CNT_W-1 in FREE (no wrap-around).
REQ-019 SHALL, in BURST, stay in RUN for exactly burst_len cycles, then go to FINISH.
REQ-020 SHALL, in BURST with burst_len=0, go directly IDLE->FINISH with no step_en cycles.
REQ-021 SHALL, in STEP, stay in RUN for exactly one cycle.
REQ-022 SHALL, in FREE, stay in RUN until stop.
REQ-023 SHALL treat stop in RUN as an exit to FINISH on the next edge; the cycle in which stop is sampled still counts as a RUN cycle.
REQ-024 SHALL let stop take priority over a BURST terminal count in the same cycle; the result is identical.
REQ-025 SHALL assert done for one cycle in FINISH, then return to IDLE.
REQ-026 SHALL ignore start outside IDLE, including start and stop asserted together.
REQ-027 SHALL make step_en a registered output; first step_en is 1 cycle after the start edge.

Reset
REQ-028 SHALL, while reset_n is low, force state IDLE, step_en=0, busy=0, done=0, cycles_run=0 and latched mask=0, asynchronously.
REQ-029 SHALL, when reset occurs mid-run, abort the run with no done pulse.
REQ-030 SHALL take the first start accepted on the rising edge after reset_n is released.

Configuration
REQ-031 SHALL, with macro MIPS_CYCLE_CTRL_BKPT_EN defined, add input bkpt_pc (32 bits), input pc (32 bits), input bkpt_valid (1 bit) and output bkpt_hit (1 bit).
REQ-032 SHALL, with MIPS_CYCLE_CTRL_BKPT_EN defined, treat pc==bkpt_pc with bkpt_valid in RUN like stop, and assert bkpt_hit together with done.
REQ-033 SHALL, without MIPS_CYCLE_CTRL_BKPT_EN, omit these ports and the comparator; behaviour is otherwise identical.

Structure
REQ-034 SHALL define mode encodings, FSM state encodings and the CNT_W default in shared package mips_pkg.
REQ-035 SHALL use one sub-module, mips_sat_counter (parametrised CNT_W, clear/increment/saturate), for cycles_run.

Verification
REQ-036 SHALL cover BURST with burst_len=9 and ch_mask=1: 9 consecutive step_en cycles, done 1 cycle after the last, cycles_run=9.
REQ-037 SHALL cover STEP: exactly one step_en cycle, then done; start held high re-arms only after IDLE.
REQ-038 SHALL cover FREE with stop after 5 cycles: cycles_run=6 (stop cycle counted), done pulse.
REQ-039 SHALL cover BURST with burst_len=0: no step_en, done on the next cycle, cycles_run=0.
REQ-040 SHALL cover reset_n low in RUN at cycle 3: step_en=0 immediately, no done, cycles_run=0.
REQ-041 SHALL cover CNT_W=4 in FREE for 20 cycles: cycles_run saturates at 15; N_CH=3 with mask 3'b101 gives step_en=3'b101.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS cycle controller: run modes, FSM states, default counter width.
// No logic; no latency; no backpressure.
package mips_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'd0,
        MODE_FREE  = 2'd1,
        MODE_BURST = 2'd2,
        MODE_STEP  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/mips_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
// Latency: count visible the cycle after clr/inc; no backpressure.
module mips_sat_counter #(
    parameter int CNT_W = mips_pkg::CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mips_cycle_ctrl.sv
// Core run controller: IDLE/RUN/FINISH FSM gating per-channel step enables (FREE/BURST/STEP), optional PC breakpoint via MIPS_CYCLE_CTRL_BKPT_EN.
// Latency: first step_en one cycle after the accepted start edge; done one cycle after the last RUN cycle.
// Backpressure: none; start is ignored outside IDLE, stop/breakpoint end a run on the next edge.
module mips_cycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_CH  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [N_CH-1:0]  ch_mask,
`ifdef MIPS_CYCLE_CTRL_BKPT_EN
    input  logic [31:0]      bkpt_pc,
    input  logic [31:0]      pc,
    input  logic             bkpt_valid,
    output logic             bkpt_hit,
`endif
    output logic [N_CH-1:0]  step_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles_run
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [N_CH-1:0]  step_en_q, step_en_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             bkpt_stop;
    logic             run_stop;

`ifdef MIPS_CYCLE_CTRL_BKPT_EN
    logic hit_q;

    assign bkpt_stop = bkpt_valid && (pc == bkpt_pc);

    // Remember why the run ended so the hit flag lines up with the done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= 1'b0;
        end else if (state_q == ST_RUN && state_d == ST_FINISH) begin
            hit_q <= bkpt_stop;
        end else if (state_q == ST_IDLE) begin
            hit_q <= 1'b0;
        end
    end

    assign bkpt_hit = done & hit_q;
`else
    assign bkpt_stop = 1'b0;
`endif

    assign run_stop = stop | bkpt_stop;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (mode_e'(mode) != MODE_HALT)) begin
                    mode_d  = mode_e'(mode);
                    mask_d  = ch_mask;
                    rem_d   = burst_len;
                    cnt_clr = 1'b1;
                    if (mode_e'(mode) == MODE_BURST && burst_len == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_inc = 1'b1;
                if (mode_q == MODE_BURST) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                // Stop and a burst terminal count both land in FINISH, so no ordering is needed.
                if (run_stop || (mode_q == MODE_STEP) ||
                    (mode_q == MODE_BURST && rem_q == CNT_W'(1))) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        step_en_d = (state_d == ST_RUN) ? mask_d : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_HALT;
            mask_q    <= '0;
            rem_q     <= '0;
            step_en_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            rem_q     <= rem_d;
            step_en_q <= step_en_d;
        end
    end

    mips_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycles (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cycles_run)
    );

    assign step_en = step_en_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_FINISH);

endmodule

// File: tb/tb_mips_cycle_ctrl.sv
// Bench for mips_cycle_ctrl: vector table with expectation queue plus hand-written corner sequences.
module tb_mips_cycle_ctrl;
    import mips_pkg::*;

    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic [0:0]    ch_mask = '0;
    logic [0:0]    step_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycles_run;

    logic [1:0]    m4 = 2'd0;
    logic          start4 = 1'b0;
    logic          stop4 = 1'b0;
    logic [3:0]    bl4 = '0;
    logic [2:0]    mask4 = '0;
    logic [2:0]    step4;
    logic          busy4;
    logic          done4;
    logic [3:0]    cyc4;

`ifdef MIPS_CYCLE_CTRL_BKPT_EN
    logic bkpt_hit;
    logic bkpt_hit4;
`endif

    mips_cycle_ctrl #(.CNT_W(CW), .N_CH(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .ch_mask    (ch_mask),
`ifdef MIPS_CYCLE_CTRL_BKPT_EN
        .bkpt_pc    (32'h0),
        .pc         (32'h1),
        .bkpt_valid (1'b0),
        .bkpt_hit   (bkpt_hit),
`endif
        .step_en    (step_en),
        .busy       (busy),
        .done       (done),
        .cycles_run (cycles_run)
    );

    mips_cycle_ctrl #(.CNT_W(4), .N_CH(3)) dut4 (
        .clock      (clock),
        .reset_n    (reset_n),
        .mode       (m4),
        .start      (start4),
        .stop       (stop4),
        .burst_len  (bl4),
        .ch_mask    (mask4),
`ifdef MIPS_CYCLE_CTRL_BKPT_EN
        .bkpt_pc    (32'h0),
        .pc         (32'h1),
        .bkpt_valid (1'b0),
        .bkpt_hit   (bkpt_hit4),
`endif
        .step_en    (step4),
        .busy       (busy4),
        .done       (done4),
        .cycles_run (cyc4)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] blen;
        logic        mask;
        int          stop_cyc;   // RUN cycle index in which stop is held; 0 = never
        int          exp_busy;   // expected number of RUN cycles
        int          exp_cyc;    // expected cycles_run at done
    } vec_t;

    typedef struct {
        int busy_n;
        int cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   busy_n;
        bit   seen;
        @(negedge clock);
        mode      = v.mode;
        burst_len = v.blen;
        ch_mask   = v.mask;
        start     = 1'b1;
        e.busy_n  = v.exp_busy;
        e.cyc     = v.exp_cyc;
        sb.push_back(e);
        busy_n = 0;
        seen   = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clock);
            start = 1'b0;
            stop  = 1'b0;
            if (t == 0) check("first_cycle_busy", {31'd0, busy}, {31'd0, (v.exp_busy != 0)});
            if (busy) begin
                busy_n++;
                check("step_en_in_run", {31'd0, step_en}, {31'd0, v.mask});
                if (busy_n == v.stop_cyc) stop = 1'b1;
            end else if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check("run_length", busy_n, e.busy_n);
                check("cycles_run_at_done", {16'd0, cycles_run}, e.cyc);
                check("step_en_in_finish", {31'd0, step_en}, 32'd0);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got no done expected done within 200 cycles");
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clock);
        check("done_one_cycle", {30'd0, busy, done}, 32'd0);
    endtask

    logic [1:0] hold_pat[6];

    initial begin
        vecs[0] = '{MODE_BURST, 16'd9, 1'b1, 0, 9, 9};
        vecs[1] = '{MODE_STEP,  16'd0, 1'b1, 0, 1, 1};
        vecs[2] = '{MODE_FREE,  16'd0, 1'b1, 6, 6, 6};
        vecs[3] = '{MODE_BURST, 16'd0, 1'b1, 0, 0, 0};
        vecs[4] = '{MODE_BURST, 16'd5, 1'b1, 3, 3, 3};
        vecs[5] = '{MODE_BURST, 16'd4, 1'b1, 4, 4, 4};
        vecs[6] = '{MODE_BURST, 16'd1, 1'b1, 0, 1, 1};
        vecs[7] = '{MODE_STEP,  16'd0, 1'b0, 0, 1, 1};
        hold_pat = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_step_en", {31'd0, step_en}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_cycles_run", {16'd0, cycles_run}, 32'd0);
        check("rst_step4", {29'd0, step4}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // HALT start ignored
        @(negedge clock);
        mode  = MODE_HALT;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("halt_ignored", {30'd0, busy, done}, 32'd0);
        @(negedge clock);
        check("halt_no_done", {30'd0, busy, done}, 32'd0);

        // STEP with start held: re-arms only after IDLE
        mode    = MODE_STEP;
        ch_mask = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("step_hold_busy_done", {30'd0, busy, done}, {30'd0, hold_pat[i]});
        end
        start = 1'b0;

        // start+stop together in RUN: stop honoured, start ignored
        @(negedge clock);
        mode  = MODE_FREE;
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 3) begin
                start = 1'b1;
                stop  = 1'b1;
                mode  = MODE_STEP;
            end
        end
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_done", {30'd0, busy, done}, 32'd1);
        check("startstop_cycles", {16'd0, cycles_run}, 32'd3);
        @(negedge clock);
        check("startstop_idle", {30'd0, busy, done}, 32'd0);
        check("startstop_hold_cnt", {16'd0, cycles_run}, 32'd3);

        // Reset in RUN cycle 3
        @(negedge clock);
        mode      = MODE_BURST;
        burst_len = 16'd9;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_step_en", {31'd0, step_en}, 32'd0);
        check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        check("midrst_cycles", {16'd0, cycles_run}, 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        reset_n = 1'b1;
        mode    = MODE_STEP;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("first_start_after_rst", {30'd0, busy, done}, 32'd2);
        @(negedge clock);
        check("post_rst_done", {30'd0, busy, done}, 32'd1);
        check("post_rst_cycles", {16'd0, cycles_run}, 32'd1);

        // CNT_W=4, N_CH=3: FREE for 20 cycles saturates at 15
        @(negedge clock);
        m4     = MODE_FREE;
        mask4  = 3'b101;
        start4 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            start4 = 1'b0;
            check("w4_step_en", {29'd0, step4}, 32'd5);
            if (k == 20) stop4 = 1'b1;
        end
        @(negedge clock);
        stop4 = 1'b0;
        check("w4_done", {30'd0, busy4, done4}, 32'd1);
        check("w4_saturated", {28'd0, cyc4}, 32'd15);
        check("w4_step_en_off", {29'd0, step4}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
